// File: rtl/audio_fx_engine.sv
// Stereo audio effects engine sitting between the ADC FIFO and the DAC FIFO.
// One packed {left,right} sample is popped, run through the selected effect
// (bypass, clip+gain distortion, single-tap delay, feedback echo) and pushed.
// A circular delay RAM advances one entry per sample and is zero-filled after
// every reset before the first pop.
module audio_fx_engine #(
   parameter int SAMPLE_W  = 16,
   parameter int DELAY_AW  = 13,
   parameter int DIST_GAIN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  empty_adc,
   output logic                  rd_adc,
   input  logic [2*SAMPLE_W-1:0] adc_fifo_out,
   input  logic                  full_dac,
   output logic                  wr_dac,
   output logic [2*SAMPLE_W-1:0] dac_fifo_in,
   input  logic [1:0]            mode,
   input  logic [SAMPLE_W-2:0]   clip_thresh,
   input  logic [DELAY_AW-1:0]   delay_len,
   input  logic [2:0]            fb_shift,
   output logic                  busy
);

   localparam int EXT_W = SAMPLE_W + 2;
   localparam int DEPTH = 1 << DELAY_AW;
   localparam logic [DELAY_AW-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_READ,
      S_CALC,
      S_WRITE
   } state_t;

   state_t state, state_nxt;

   logic [DELAY_AW-1:0]   wr_ptr;
   logic [DELAY_AW-1:0]   eff_len;
   logic [DELAY_AW-1:0]   rd_addr;
   logic [2*SAMPLE_W-1:0] ram [DEPTH];
   logic                  ram_we;
   logic [2*SAMPLE_W-1:0] ram_wdata;

   // operands held for the sample being processed
   logic [2*SAMPLE_W-1:0] x_p1;
   logic [2*SAMPLE_W-1:0] d_p1;
   logic [1:0]            mode_p1;
   logic [SAMPLE_W-2:0]   thresh_p1;
   logic [2:0]            shift_p1;

   logic signed [SAMPLE_W-1:0] y_l, y_r;
   logic [2*SAMPLE_W-1:0]      y_word;

   // Saturate an extended-width value into the signed sample range.
   function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [EXT_W-1:0] v);
      logic signed [EXT_W-1:0] hi, lo;
      hi = {3'b000, {(SAMPLE_W-1){1'b1}}};
      lo = {3'b111, {(SAMPLE_W-1){1'b0}}};
      if (v > hi)      return hi[SAMPLE_W-1:0];
      else if (v < lo) return lo[SAMPLE_W-1:0];
      else             return v[SAMPLE_W-1:0];
   endfunction

   // Clamp a sample to the symmetric window [-t, +t].
   function automatic logic signed [SAMPLE_W-1:0] clamp_sym(input logic signed [SAMPLE_W-1:0] x,
                                                            input logic [SAMPLE_W-2:0] t);
      logic signed [SAMPLE_W-1:0] pos, neg;
      pos = signed'({1'b0, t});
      neg = -pos;
      if (x > pos)      return pos;
      else if (x < neg) return neg;
      else              return x;
   endfunction

   // One channel of the effect; all arithmetic is done two bits wider, then saturated.
   function automatic logic signed [SAMPLE_W-1:0] fx(input logic [1:0] m,
                                                     input logic signed [SAMPLE_W-1:0] x,
                                                     input logic signed [SAMPLE_W-1:0] d,
                                                     input logic [SAMPLE_W-2:0] t,
                                                     input logic [2:0] sh);
      logic signed [EXT_W-1:0]    xe, de, ce, acc;
      logic signed [SAMPLE_W-1:0] c;
      xe  = {{2{x[SAMPLE_W-1]}}, x};
      de  = {{2{d[SAMPLE_W-1]}}, d};
      c   = clamp_sym(x, t);
      ce  = {{2{c[SAMPLE_W-1]}}, c};
      acc = xe;
      case (m)
         2'd0: acc = xe;
         2'd1: acc = ce <<< DIST_GAIN;
         2'd2: acc = (xe >>> 1) + (de >>> 1);
         default: acc = xe + (de >>> sh);
      endcase
      return sat(acc);
   endfunction

   // State register; reset restarts the RAM clear and drops any in-flight sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_CLEAR;
      else        state <= state_nxt;
   end

   // Next-state and FIFO handshakes; pops only in IDLE, pushes only in WRITE.
   always_comb begin
      state_nxt = state;
      rd_adc    = 1'b0;
      wr_dac    = 1'b0;
      case (state)
         S_CLEAR: if (wr_ptr == LAST_ADDR) state_nxt = S_IDLE;
         S_IDLE: begin
            rd_adc = !empty_adc;
            if (!empty_adc) state_nxt = S_READ;
         end
         S_READ:  state_nxt = S_CALC;
         S_CALC:  state_nxt = S_WRITE;
         S_WRITE: begin
            wr_dac = !full_dac;
            if (!full_dac) state_nxt = S_IDLE;
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   assign busy = (state == S_CLEAR);

   // Write pointer sweeps the RAM during clear and advances once per sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  wr_ptr <= '0;
      else if (state == S_CLEAR || state == S_CALC) wr_ptr <= wr_ptr + 1'b1;
   end

   // A zero delay length behaves as one sample so the tap never aliases the write slot.
   always_comb begin
      eff_len = (delay_len == '0) ? DELAY_AW'(1) : delay_len;
      rd_addr = wr_ptr - eff_len;
   end

   // ---- READ -> CALC boundary: capture input sample, controls and delayed tap ----
   always_ff @(posedge clk) begin
      if (state == S_READ) begin
         x_p1      <= adc_fifo_out;
         d_p1      <= ram[rd_addr];
         mode_p1   <= mode;
         thresh_p1 <= clip_thresh;
         shift_p1  <= fb_shift;
      end
   end

   // Per-channel effect evaluated from the held operands.
   always_comb begin
      y_l    = fx(mode_p1, x_p1[2*SAMPLE_W-1:SAMPLE_W], d_p1[2*SAMPLE_W-1:SAMPLE_W], thresh_p1, shift_p1);
      y_r    = fx(mode_p1, x_p1[SAMPLE_W-1:0], d_p1[SAMPLE_W-1:0], thresh_p1, shift_p1);
      y_word = {y_l, y_r};
   end

   // RAM write source: zeros while clearing, then the dry input (or the output in echo mode).
   always_comb begin
      ram_we    = (state == S_CLEAR) || (state == S_CALC);
      ram_wdata = '0;
      if (state == S_CALC) ram_wdata = (mode_p1 == 2'd3) ? y_word : x_p1;
   end

   // Delay RAM write port.
   always_ff @(posedge clk) begin
      if (ram_we) ram[wr_ptr] <= ram_wdata;
   end

   // ---- CALC -> WRITE boundary: register the processed word for the DAC FIFO ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               dac_fifo_in <= '0;
      else if (state == S_CALC) dac_fifo_in <= y_word;
   end

endmodule

// File: tb/tb_audio_fx_engine.sv
// Self-checking bench for audio_fx_engine: directed spec scenarios plus
// randomized streams compared against a sample-history reference model.
module tb_audio_fx_engine;

   localparam int SW    = 16;
   localparam int AW    = 8;
   localparam int DG    = 1;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          empty_adc;
   logic          rd_adc;
   logic [31:0]   adc_fifo_out;
   logic          full_dac;
   logic          wr_dac;
   logic [31:0]   dac_fifo_in;
   logic [1:0]    mode;
   logic [SW-2:0] clip_thresh;
   logic [AW-1:0] delay_len;
   logic [2:0]    fb_shift;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] in_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] chk_q[$];
   logic [31:0] hist[$];

   audio_fx_engine #(.SAMPLE_W(SW), .DELAY_AW(AW), .DIST_GAIN(DG)) dut (
      .clk(clk), .rst_n(rst_n), .empty_adc(empty_adc), .rd_adc(rd_adc),
      .adc_fifo_out(adc_fifo_out), .full_dac(full_dac), .wr_dac(wr_dac),
      .dac_fifo_in(dac_fifo_in), .mode(mode), .clip_thresh(clip_thresh),
      .delay_len(delay_len), .fb_shift(fb_shift), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int sat16(int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int ref_ch(int x, int d);
      int t, c, y;
      t = int'(clip_thresh);
      case (int'(mode))
         0: y = x;
         1: begin
            c = (x > t) ? t : ((x < -t) ? -t : x);
            y = c * (1 << DG);
         end
         2: y = (x >>> 1) + (d >>> 1);
         default: y = x + (d >>> int'(fb_shift));
      endcase
      return sat16(y);
   endfunction

   // Reference: the tap is whatever was stored L samples ago (zero before that).
   function automatic logic [31:0] model(logic [31:0] w);
      int L, n, xl, xr, dl, dr, yl, yr;
      logic [31:0] dw, yw;
      L  = (delay_len == 0) ? 1 : int'(delay_len);
      n  = hist.size();
      dw = (n >= L) ? hist[n-L] : 32'h0;
      xl = int'($signed(w[31:16]));
      xr = int'($signed(w[15:0]));
      dl = int'($signed(dw[31:16]));
      dr = int'($signed(dw[15:0]));
      yl = ref_ch(xl, dl);
      yr = ref_ch(xr, dr);
      yw = {16'(yl), 16'(yr)};
      hist.push_back((mode == 2'd3) ? yw : w);
      return yw;
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [15:0] h[2];
      for (int i = 0; i < 2; i++) begin
         case ($urandom_range(9))
            0: h[i] = 16'h7FFF;
            1: h[i] = 16'h8000;
            2: h[i] = 16'h0000;
            default: h[i] = 16'($urandom);
         endcase
      end
      return {h[0], h[1]};
   endfunction

   task automatic do_reset();
      int cnt, bad;
      @(negedge clk);
      rst_n = 1'b0; empty_adc = 1'b0; full_dac = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
      n_cmp++; if (rd_adc !== 1'b0) begin n_bad++; $display("FAIL reset_rd_adc: got %b expected 0", rd_adc); end
      n_cmp++; if (wr_dac !== 1'b0) begin n_bad++; $display("FAIL reset_wr_dac: got %b expected 0", wr_dac); end
      n_cmp++; if (dac_fifo_in !== 32'h0) begin n_bad++; $display("FAIL reset_dac: got %h expected 0", dac_fifo_in); end
      hist.delete(); exp_q.delete(); chk_q.delete(); in_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cnt = 0; bad = 0;
      while (busy === 1'b1 && cnt < DEPTH + 16) begin
         cnt++;
         if (rd_adc !== 1'b0 || wr_dac !== 1'b0 || dac_fifo_in !== 32'h0) bad++;
         @(negedge clk); #1;
      end
      n_cmp++; if (cnt != DEPTH) begin n_bad++; $display("FAIL clear_busy_len: got %0d expected %0d", cnt, DEPTH); end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clear_quiet: got %0d bad cycles expected 0", bad); end
      n_cmp++; if (rd_adc !== 1'b1) begin n_bad++; $display("FAIL idle_pop_after_clear: got %b expected 1", rd_adc); end
      empty_adc = 1'b1;
      #1;
   endtask

   // Drains in_q through the DUT, checking each push against the model (and chk_q if loaded).
   task automatic run_stream(input int stall_pct, input int max_cycles);
      int cyc, t_rd, t_prev;
      bit have_pend;
      logic [31:0] pend, e;
      cyc = 0; t_rd = -1; t_prev = -1; have_pend = 0; pend = '0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
         @(negedge clk);
         if (have_pend) begin adc_fifo_out = pend; have_pend = 0; end
         else adc_fifo_out = $urandom;
         empty_adc = (in_q.size() == 0);
         full_dac  = ($urandom_range(99) < stall_pct);
         #1;
         if (rd_adc === 1'b1) begin
            pend = in_q.pop_front();
            have_pend = 1;
            exp_q.push_back(model(pend));
            t_prev = t_rd;
            t_rd = cyc;
            if (stall_pct == 0 && t_prev >= 0) begin
               n_cmp++;
               if (t_rd - t_prev != 4) begin n_bad++; $display("FAIL pop_spacing: got %0d expected 4", t_rd - t_prev); end
            end
         end
         if (wr_dac === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL spurious_push: got %h expected none", dac_fifo_in);
            end else begin
               e = exp_q.pop_front();
               if (dac_fifo_in !== e) begin n_bad++; $display("FAIL push_data: got %h expected %h", dac_fifo_in, e); end
            end
            if (chk_q.size() > 0) begin
               e = chk_q.pop_front();
               n_cmp++;
               if (dac_fifo_in !== e) begin n_bad++; $display("FAIL push_const: got %h expected %h", dac_fifo_in, e); end
            end
            if (stall_pct == 0) begin
               n_cmp++;
               if (cyc - t_rd != 3) begin n_bad++; $display("FAIL latency: got %0d expected 3", cyc - t_rd); end
            end
         end
         cyc++;
      end
      @(negedge clk);
      empty_adc = 1'b1; full_dac = 1'b0;
      n_cmp++;
      if (in_q.size() != 0 || exp_q.size() != 0 || chk_q.size() != 0) begin
         n_bad++;
         $display("FAIL stream_timeout: got %0d/%0d/%0d left expected 0/0/0", in_q.size(), exp_q.size(), chk_q.size());
         in_q.delete(); exp_q.delete(); chk_q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_bypass();
      mode = 2'd0;
      in_q.push_back(32'h1234ABCD);
      chk_q.push_back(32'h1234ABCD);
      run_stream(0, 100);
   endtask

   task automatic test_distortion();
      mode = 2'd1; clip_thresh = 15'd32;
      in_q.push_back({16'sd100, -16'sd100});
      in_q.push_back({16'sd10, -16'sd5});
      chk_q.push_back(32'h0040FFC0);
      chk_q.push_back(32'h0014FFF6);
      run_stream(0, 100);
   endtask

   task automatic test_delay();
      do_reset();
      mode = 2'd2; delay_len = 8'd4;
      in_q.push_back(32'h03E803E8);
      for (int i = 1; i < 8; i++) in_q.push_back(32'h0);
      for (int i = 0; i < 8; i++) chk_q.push_back((i % 4 == 0) ? 32'h01F401F4 : 32'h0);
      run_stream(0, 200);
   endtask

   task automatic test_echo();
      do_reset();
      mode = 2'd3; delay_len = 8'd4; fb_shift = 3'd1;
      in_q.push_back(32'h03E803E8);
      for (int i = 1; i < 12; i++) in_q.push_back(32'h0);
      for (int i = 0; i < 12; i++)
         chk_q.push_back((i == 0) ? 32'h03E803E8 : (i == 4) ? 32'h01F401F4 : (i == 8) ? 32'h00FA00FA : 32'h0);
      run_stream(0, 200);
   endtask

   task automatic test_saturation();
      do_reset();
      mode = 2'd3; delay_len = 8'd4; fb_shift = 3'd0;
      for (int i = 0; i < 8; i++) begin
         in_q.push_back(32'h75308AD0);
         chk_q.push_back((i < 4) ? 32'h75308AD0 : 32'h7FFF8000);
      end
      run_stream(0, 200);
   endtask

   task automatic test_full_stall();
      logic [31:0] a;
      bit got;
      int cnt;
      a = 32'hCAFE1357;
      mode = 2'd0;
      @(negedge clk);
      empty_adc = 1'b0; full_dac = 1'b1;
      #1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (rd_adc === 1'b1) got = 1;
         else begin @(negedge clk); #1; end
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL stall_pop: got 0 expected 1"); empty_adc = 1'b1; full_dac = 1'b0; return; end
      void'(model(a));
      @(negedge clk);
      adc_fifo_out = a;
      #1;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (wr_dac !== 1'b0 || rd_adc !== 1'b0) begin
            n_bad++; $display("FAIL stall_handshake: got wr=%b rd=%b expected 0 0", wr_dac, rd_adc);
         end
         if (i >= 1) begin
            n_cmp++;
            if (dac_fifo_in !== a) begin n_bad++; $display("FAIL stall_hold: got %h expected %h", dac_fifo_in, a); end
         end
      end
      empty_adc = 1'b1; full_dac = 1'b0;
      #1;
      n_cmp++;
      if (wr_dac !== 1'b1 || dac_fifo_in !== a) begin
         n_bad++; $display("FAIL stall_release: got wr=%b %h expected 1 %h", wr_dac, dac_fifo_in, a);
      end
      cnt = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (wr_dac === 1'b1) cnt++;
      end
      n_cmp++;
      if (cnt != 1) begin n_bad++; $display("FAIL stall_single_push: got %0d expected 1", cnt); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         mode        = 2'($urandom_range(3));
         clip_thresh = ($urandom_range(1) == 0) ? 15'($urandom_range(300)) : 15'($urandom);
         delay_len   = ($urandom_range(4) == 0) ? 8'd0 : 8'($urandom);
         fb_shift    = 3'($urandom_range(7));
         for (int i = 0; i < 60; i++) in_q.push_back(rnd_word());
         run_stream((r % 2 == 0) ? 30 : 0, 3000);
      end
   endtask

   task automatic test_reset_midflight();
      bit got;
      mode = 2'd2; delay_len = 8'd1;
      @(negedge clk);
      empty_adc = 1'b0;
      #1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (rd_adc === 1'b1) got = 1;
         else begin @(negedge clk); #1; end
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL midflight_pop: got 0 expected 1"); end
      do_reset();
      in_q.push_back(32'h0100FF00);
      chk_q.push_back(32'h0080FF80);
      run_stream(0, 100);
   endtask

   task automatic test_back_to_back();
      mode = 2'd0;
      for (int i = 0; i < 12; i++) in_q.push_back(rnd_word());
      run_stream(0, 200);
   endtask

   initial begin
      rst_n = 1'b0; empty_adc = 1'b1; full_dac = 1'b0; adc_fifo_out = '0;
      mode = 2'd0; clip_thresh = '0; delay_len = '0; fb_shift = '0;
      test_reset();
      test_bypass();
      test_distortion();
      test_delay();
      test_echo();
      test_saturation();
      test_full_stall();
      test_random();
      test_reset_midflight();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
